mfp_timer_gen: RTL and testbench

Parametrised MFP-style timer channel: a WIDTH-bit reloading down-counter with delay, pulse-width and event-count modes, a one-shot option, a selectable input edge/level polarity, and a sticky interrupt-pending/overrun pair with acknowledge. It replaces the fixed 8-bit timer inside the MFP and is instantiated once per timer (A–D). It runs entirely in the CLK domain: the external timer clock arrives as a one-cycle enable, not as a clock.

---
 rtl/mfp_timer_pkg.sv | 38 +++
 rtl/mfp_timer_gen_if.sv | 21 ++
 rtl/mfp_timer_prescaler.sv | 36 +++
 rtl/mfp_timer_gen.sv | 134 +++++++++++++
 tb/tb_mfp_timer_gen.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mfp_timer_pkg.sv
// Shared constants and helpers for the MFP timer channel: mode codes,
// control-register bit positions and the prescaler divisor table.
package mfp_timer_pkg;

  localparam logic [1:0] MODE_STOP  = 2'd0;
  localparam logic [1:0] MODE_DELAY = 2'd1;
  localparam logic [1:0] MODE_EVENT = 2'd2;
  localparam logic [1:0] MODE_PULSE = 2'd3;

  localparam int CTRL_MODE      = 3;
  localparam int CTRL_ONESHOT   = 4;
  localparam int CTRL_POL       = 5;
  localparam int CTRL_FORCE_LOW = 6;

  localparam int PSC_W = 8;

  function automatic logic [1:0] decode_mode(input logic [3:0] m);
    if (m == 4'd0)      return MODE_STOP;
    else if (m == 4'd8) return MODE_EVENT;
    else if (m[3])      return MODE_PULSE;
    else                return MODE_DELAY;
  endfunction

  // Select 0 never reaches the prescaler while it runs; 1 keeps it harmless.
  function automatic logic [PSC_W-1:0] psc_div(input logic [2:0] sel);
    case (sel)
      3'd1:    return PSC_W'(4);
      3'd2:    return PSC_W'(10);
      3'd3:    return PSC_W'(16);
      3'd4:    return PSC_W'(50);
      3'd5:    return PSC_W'(64);
      3'd6:    return PSC_W'(100);
      3'd7:    return PSC_W'(200);
      default: return PSC_W'(1);
    endcase
  endfunction

endpackage

// File: rtl/mfp_timer_gen_if.sv
// CPU-side register bus of one timer channel: data and control
// write strobes plus the readback paths.
interface mfp_timer_gen_if #(parameter int WIDTH = 8);
  logic             DS;
  logic             DAT_WE;
  logic [WIDTH-1:0] DAT_I;
  logic [WIDTH-1:0] DAT_O;
  logic             CTRL_WE;
  logic [6:0]       CTRL_I;
  logic [5:0]       CTRL_O;

  modport master (
    output DS, DAT_WE, DAT_I, CTRL_WE, CTRL_I,
    input  DAT_O, CTRL_O
  );

  modport slave (
    input  DS, DAT_WE, DAT_I, CTRL_WE, CTRL_I,
    output DAT_O, CTRL_O
  );
endinterface

// File: rtl/mfp_timer_prescaler.sv
// Divides the timer-clock enable by the selected divisor; wrap is a
// combinational strobe on the XCLK_EN cycle that completes a period.
module mfp_timer_prescaler
  import mfp_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       xclk_en,
  input  logic       run,
  input  logic [2:0] sel,
  output logic       wrap
);

  logic [PSC_W-1:0] cnt_q, cnt_d;
  logic [PSC_W-1:0] last;

  // NOTE: every signal gets a default at the top of always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    last  = psc_div(sel) - PSC_W'(1);
    // >= rather than == so a shrinking divisor on a live write cannot strand the count.
    wrap  = run && xclk_en && (cnt_q >= last);
    cnt_d = cnt_q;
    if (!run)         cnt_d = '0;
    else if (wrap)    cnt_d = '0;
    else if (xclk_en) cnt_d = cnt_q + PSC_W'(1);
  end

  // NOTE: state updates use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mfp_timer_gen.sv
// One MFP timer channel: reloading down-counter with delay, pulse-width
// and event modes, one-shot, polarity select and sticky IRQ/overrun.
module mfp_timer_gen
  import mfp_timer_pkg::*;
#(
  parameter int WIDTH = 8
)
(
  input  logic          CLK,
  input  logic          RST,
  input  logic          CLK_EN,
  input  logic          XCLK_EN,
  mfp_timer_gen_if.slave bus,
  input  logic          T_I,
  input  logic          IRQ_ACK,
  output logic          T_O,
  output logic          T_O_PULSE,
  output logic          IRQ_O,
  output logic          OVR_O,
  output logic          PULSE_MODE,
  output logic          EVENT_MODE
);

  logic [WIDTH-1:0] data_q,  data_d;
  logic [WIDTH-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] dat_o_q, dat_o_d;
  logic [5:0]       ctrl_q,  ctrl_d;
  logic [2:0]       sync_q,  sync_d;
  logic             ds_q,    ds_d;
  logic             t_o_q,   t_o_d;
  logic             t_o_pulse_q, t_o_pulse_d;
  logic             irq_q,   irq_d;
  logic             ovr_q,   ovr_d;

  logic [1:0] mode;
  logic       run;
  logic       psc_wrap;
  logic       act_level;
  logic       act_edge;
  logic       cnt_tick;
  logic       timeout;

  mfp_timer_prescaler u_psc (
    .clk     (CLK),
    .rst     (RST),
    .xclk_en (XCLK_EN),
    .run     (run),
    .sel     (ctrl_q[2:0]),
    .wrap    (psc_wrap)
  );

  always_comb begin
    mode      = decode_mode(ctrl_q[3:0]);
    run       = (mode == MODE_DELAY) || (mode == MODE_PULSE);
    // Stage 2 is the settled level; stage 3 lags it by one sample for edge detection.
    act_level = sync_q[1];
    act_edge  = sync_q[1] & ~sync_q[2];
    case (mode)
      MODE_DELAY: cnt_tick = psc_wrap;
      MODE_PULSE: cnt_tick = psc_wrap & act_level;
      MODE_EVENT: cnt_tick = CLK_EN & act_edge;
      default:    cnt_tick = 1'b0;
    endcase
    timeout = cnt_tick && (cnt_q == WIDTH'(1));
  end

  always_comb begin
    sync_d = CLK_EN ? {sync_q[1:0], T_I ^ ctrl_q[CTRL_POL]} : sync_q;
    data_d = bus.DAT_WE ? bus.DAT_I : data_q;

    cnt_d = cnt_q;
    if (bus.DAT_WE && mode == MODE_STOP) cnt_d = bus.DAT_I;
    else if (timeout)                    cnt_d = data_q;
    else if (cnt_tick)                   cnt_d = cnt_q - WIDTH'(1);

    ctrl_d = ctrl_q;
    if (bus.CTRL_WE)                          ctrl_d = bus.CTRL_I[5:0];
    else if (timeout && ctrl_q[CTRL_ONESHOT]) ctrl_d[3:0] = 4'd0;

    t_o_d = t_o_q;
    if (bus.CTRL_WE && bus.CTRL_I[CTRL_FORCE_LOW]) t_o_d = 1'b0;
    else if (timeout)                              t_o_d = ~t_o_q;

    t_o_pulse_d = timeout;

    irq_d = irq_q;
    if (timeout)      irq_d = 1'b1;
    else if (IRQ_ACK) irq_d = 1'b0;

    // An acknowledge always clears overrun, even alongside a fresh timeout.
    ovr_d = ovr_q;
    if (IRQ_ACK)               ovr_d = 1'b0;
    else if (timeout && irq_q) ovr_d = 1'b1;

    ds_d    = bus.DS;
    dat_o_d = (bus.DS && !ds_q) ? cnt_q : dat_o_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q      <= '0;
      cnt_q       <= '0;
      dat_o_q     <= '0;
      ctrl_q      <= '0;
      sync_q      <= '0;
      ds_q        <= 1'b0;
      t_o_q       <= 1'b0;
      t_o_pulse_q <= 1'b0;
      irq_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      dat_o_q     <= dat_o_d;
      ctrl_q      <= ctrl_d;
      sync_q      <= sync_d;
      ds_q        <= ds_d;
      t_o_q       <= t_o_d;
      t_o_pulse_q <= t_o_pulse_d;
      irq_q       <= irq_d;
      ovr_q       <= ovr_d;
    end
  end

  assign bus.DAT_O  = dat_o_q;
  assign bus.CTRL_O = ctrl_q;
  assign T_O        = t_o_q;
  assign T_O_PULSE  = t_o_pulse_q;
  assign IRQ_O      = irq_q;
  assign OVR_O      = ovr_q;
  assign PULSE_MODE = (mode == MODE_PULSE);
  assign EVENT_MODE = (mode == MODE_EVENT);

endmodule

// File: tb/tb_mfp_timer_gen.sv
// Directed bench for mfp_timer_gen: a per-cycle vector table for control,
// IRQ and force-low corners, plus sequences for the long-running modes.
module tb_mfp_timer_gen;

  logic clk = 1'b0;
  logic rst, clk_en, xclk_en, t_i, irq_ack;
  logic t_o8, tp8, irq8, ovr8, pm8, em8;
  logic t_o4, tp4, irq4, ovr4, pm4, em4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mfp_timer_gen_if #(.WIDTH(8)) bus8 ();
  mfp_timer_gen_if #(.WIDTH(4)) bus4 ();

  mfp_timer_gen #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst), .CLK_EN(clk_en), .XCLK_EN(xclk_en), .bus(bus8),
    .T_I(t_i), .IRQ_ACK(irq_ack), .T_O(t_o8), .T_O_PULSE(tp8), .IRQ_O(irq8),
    .OVR_O(ovr8), .PULSE_MODE(pm8), .EVENT_MODE(em8)
  );

  mfp_timer_gen #(.WIDTH(4)) dut4 (
    .CLK(clk), .RST(rst), .CLK_EN(clk_en), .XCLK_EN(xclk_en), .bus(bus4),
    .T_I(t_i), .IRQ_ACK(irq_ack), .T_O(t_o4), .T_O_PULSE(tp4), .IRQ_O(irq4),
    .OVR_O(ovr4), .PULSE_MODE(pm4), .EVENT_MODE(em4)
  );

  typedef struct {
    logic       rst, xclk, dwe;
    logic [7:0] dat;
    logic       cwe;
    logic [6:0] ctl;
    logic       ack;
    logic [5:0] e_ctrl;
    logic       e_pm, e_em, e_irq, e_ovr, e_to, e_tp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic x, input logic dwe, input logic [7:0] dat,
                     input logic cwe, input logic [6:0] ctl, input logic ack,
                     input logic [5:0] ec, input logic pm, input logic em, input logic irq,
                     input logic ovr, input logic to, input logic tp);
    vec_t v;
    v.rst = r; v.xclk = x; v.dwe = dwe; v.dat = dat; v.cwe = cwe; v.ctl = ctl; v.ack = ack;
    v.e_ctrl = ec; v.e_pm = pm; v.e_em = em; v.e_irq = irq; v.e_ovr = ovr; v.e_to = to; v.e_tp = tp;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic xtick();
    xclk_en = 1'b1;
    step();
    xclk_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic write8(input logic [7:0] d);
    bus8.DAT_WE = 1'b1; bus8.DAT_I = d;
    step();
    bus8.DAT_WE = 1'b0;
  endtask

  task automatic ctrl8(input logic [6:0] c);
    bus8.CTRL_WE = 1'b1; bus8.CTRL_I = c;
    step();
    bus8.CTRL_WE = 1'b0;
  endtask

  task automatic write4(input logic [3:0] d);
    bus4.DAT_WE = 1'b1; bus4.DAT_I = d;
    step();
    bus4.DAT_WE = 1'b0;
  endtask

  task automatic ctrl4(input logic [6:0] c);
    bus4.CTRL_WE = 1'b1; bus4.CTRL_I = c;
    step();
    bus4.CTRL_WE = 1'b0;
  endtask

  task automatic read8(output logic [7:0] v);
    bus8.DS = 1'b1;
    step();
    v = bus8.DAT_O;
    bus8.DS = 1'b0;
    step();
  endtask

  task automatic read4(output logic [3:0] v);
    bus4.DS = 1'b1;
    step();
    v = bus4.DAT_O;
    bus4.DS = 1'b0;
    step();
  endtask

  initial begin
    logic       exp_to;
    int         n_tp;
    logic [7:0] rd8;
    logic [3:0] rd4;

    rst = 1'b1; clk_en = 1'b1; xclk_en = 1'b0; t_i = 1'b0; irq_ack = 1'b0;
    bus8.DS = 1'b0; bus8.DAT_WE = 1'b0; bus8.DAT_I = '0; bus8.CTRL_WE = 1'b0; bus8.CTRL_I = '0;
    bus4.DS = 1'b0; bus4.DAT_WE = 1'b0; bus4.DAT_I = '0; bus4.CTRL_WE = 1'b0; bus4.CTRL_I = '0;

    //  rst x dwe dat    cwe ctl    ack  ctrl_o pm em irq ovr to tp
    add(1, 0, 0, 8'h00, 0, 7'h00, 0,  6'h00, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 8'h01, 0, 7'h00, 0,  6'h00, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 8'h00, 1, 7'h11, 0,  6'h11, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      add(0, 1, 0, 8'h00, 0, 7'h00, 0, 6'h11, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 8'h00, 0, 7'h00, 0,  6'h10, 0, 0, 1, 0, 1, 1);
    add(0, 0, 0, 8'h00, 0, 7'h00, 0,  6'h10, 0, 0, 1, 0, 1, 0);
    add(0, 1, 0, 8'h00, 0, 7'h00, 0,  6'h10, 0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 8'h00, 1, 7'h40, 0,  6'h00, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 8'h00, 0, 7'h00, 1,  6'h00, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 8'h00, 1, 7'h08, 0,  6'h08, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 8'h00, 1, 7'h09, 0,  6'h09, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 8'h00, 1, 7'h00, 0,  6'h00, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 8'h00, 1, 7'h01, 0,  6'h01, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      add(0, 1, 0, 8'h00, 0, 7'h00, 0, 6'h01, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 8'h00, 0, 7'h00, 0,  6'h01, 0, 0, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++)
      add(0, 1, 0, 8'h00, 0, 7'h00, 0, 6'h01, 0, 0, 1, 0, 1, 0);
    add(0, 1, 0, 8'h00, 0, 7'h00, 0,  6'h01, 0, 0, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++)
      add(0, 1, 0, 8'h00, 0, 7'h00, 0, 6'h01, 0, 0, 1, 1, 0, 0);
    add(0, 1, 0, 8'h00, 0, 7'h00, 1,  6'h01, 0, 0, 1, 0, 1, 1);
    add(0, 0, 0, 8'h00, 1, 7'h41, 1,  6'h01, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      add(0, 1, 0, 8'h00, 0, 7'h00, 0, 6'h01, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 8'h00, 1, 7'h41, 0,  6'h01, 0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 8'h00, 1, 7'h11, 0,  6'h11, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      add(0, 1, 0, 8'h00, 0, 7'h00, 0, 6'h11, 0, 0, 1, 0, 0, 0);
    add(0, 1, 0, 8'h00, 1, 7'h02, 0,  6'h02, 0, 0, 1, 1, 1, 1);
    add(0, 0, 0, 8'h00, 1, 7'h00, 1,  6'h00, 0, 0, 0, 0, 1, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; xclk_en = vecs[i].xclk; irq_ack = vecs[i].ack;
      bus8.DAT_WE = vecs[i].dwe; bus8.DAT_I = vecs[i].dat;
      bus8.CTRL_WE = vecs[i].cwe; bus8.CTRL_I = vecs[i].ctl;
      step();
      check($sformatf("v%0d ctrl_o", i), bus8.CTRL_O, vecs[i].e_ctrl);
      check($sformatf("v%0d pulse_mode", i), pm8, vecs[i].e_pm);
      check($sformatf("v%0d event_mode", i), em8, vecs[i].e_em);
      check($sformatf("v%0d irq", i), irq8, vecs[i].e_irq);
      check($sformatf("v%0d ovr", i), ovr8, vecs[i].e_ovr);
      check($sformatf("v%0d t_o", i), t_o8, vecs[i].e_to);
      check($sformatf("v%0d t_o_pulse", i), tp8, vecs[i].e_tp);
    end
    rst = 1'b0; xclk_en = 1'b0; irq_ack = 1'b0;
    bus8.DAT_WE = 1'b0; bus8.CTRL_WE = 1'b0;

    // Delay mode, divisor 4, reload 3: a timeout every 12 XCLK_EN pulses.
    do_reset();
    write8(8'd3);
    ctrl8(7'h01);
    exp_to = 1'b0;
    for (int n = 1; n <= 36; n++) begin
      xtick();
      check("delay tp", tp8, 32'((n % 12) == 0));
      if (n == 11) check("delay irq before", irq8, 0);
      if ((n % 12) == 0) begin
        exp_to = ~exp_to;
        check("delay t_o", t_o8, exp_to);
        check("delay irq", irq8, 1);
      end
    end
    check("delay ovr", ovr8, 1);

    // Event mode, rising edges, reload 2.
    t_i = 1'b0;
    do_reset();
    write8(8'd2);
    ctrl8(7'h08);
    check("event mode flag", em8, 1);
    n_tp = 0;
    t_i = 1'b1;
    repeat (6) begin step(); n_tp += int'(tp8); end
    t_i = 1'b0;
    repeat (6) begin step(); n_tp += int'(tp8); end
    check("event first edge no timeout", n_tp, 0);
    t_i = 1'b1;
    step(); step();
    check("event latency early", tp8, 0);
    step();
    check("event latency 3", tp8, 1);
    t_i = 1'b0;
    idle(6);

    // Event mode, active-low: falling edges count, rising edges do not.
    t_i = 1'b1;
    do_reset();
    write8(8'd2);
    idle(4);
    ctrl8(7'h28);
    n_tp = 0;
    repeat (4) begin step(); n_tp += int'(tp8); end
    t_i = 1'b0;
    repeat (6) begin step(); n_tp += int'(tp8); end
    t_i = 1'b1;
    repeat (6) begin step(); n_tp += int'(tp8); end
    check("event pol1 after one fall", n_tp, 0);
    t_i = 1'b0;
    step(); step();
    check("event pol1 early", tp8, 0);
    step();
    check("event pol1 fall timeout", tp8, 1);
    n_tp = 0;
    t_i = 1'b1;
    repeat (6) begin step(); n_tp += int'(tp8); end
    check("event pol1 rise ignored", n_tp, 0);

    // Pulse mode, WIDTH 4, divisor 10, reload 0: 16 * 10 gated pulses per timeout.
    t_i = 1'b0;
    do_reset();
    write4(4'd0);
    t_i = 1'b1;
    ctrl4(7'h0A);
    idle(3);
    check("pulse mode flag", pm4, 1);
    n_tp = 0;
    for (int n = 1; n <= 160; n++) begin
      xtick();
      n_tp += int'(tp4);
      if (n == 160) check("pulse tp at 160", tp4, 1);
    end
    check("pulse timeout count", n_tp, 1);
    repeat (25) xtick();
    read4(rd4);
    check("pulse counter gated", rd4, 4'd14);
    t_i = 1'b0;
    idle(3);
    n_tp = 0;
    repeat (200) begin xtick(); n_tp += int'(tp4); end
    check("pulse low no timeout", n_tp, 0);
    read4(rd4);
    check("pulse counter frozen", rd4, 4'd14);

    // One-shot delay, then a data write loads the stopped counter.
    do_reset();
    write8(8'd1);
    ctrl8(7'h11);
    n_tp = 0;
    for (int n = 1; n <= 12; n++) begin
      xtick();
      n_tp += int'(tp8);
      if (n == 4) begin
        check("oneshot tp", tp8, 1);
        check("oneshot ctrl", bus8.CTRL_O, 6'h10);
      end
    end
    check("oneshot single timeout", n_tp, 1);
    write8(8'd5);
    read8(rd8);
    check("oneshot dat load", rd8, 8'd5);

    // DS latches the pre-edge counter even when the counter moves that edge.
    do_reset();
    write8(8'h37);
    ctrl8(7'h01);
    repeat (3) xtick();
    bus8.DS = 1'b1; xclk_en = 1'b1;
    step();
    xclk_en = 1'b0;
    check("ds latch pre-edge", bus8.DAT_O, 8'h37);
    bus8.DS = 1'b0;
    step();
    read8(rd8);
    check("ds latch after dec", rd8, 8'h36);

    // Reset on a would-be timeout cycle clears everything, no strobe.
    do_reset();
    write8(8'd1);
    ctrl8(7'h01);
    read8(rd8);
    repeat (4) xtick();
    check("rst pre t_o", t_o8, 1);
    repeat (3) xtick();
    rst = 1'b1; xclk_en = 1'b1;
    step();
    rst = 1'b0; xclk_en = 1'b0;
    check("rst t_o", t_o8, 0);
    check("rst t_o_pulse", tp8, 0);
    check("rst irq", irq8, 0);
    check("rst ovr", ovr8, 0);
    check("rst ctrl_o", bus8.CTRL_O, 6'h00);
    check("rst dat_o", bus8.DAT_O, 8'h00);
    check("rst mode", {pm8, em8}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
